// File: rtl/rv32_core.sv
// rv32_core: single-cycle RV32I + Zicsr processor with a minimal M-mode trap
// model and an internal 64 KiB unified instruction/data memory.
//
// Ports:
//   clk  - single clock; all state changes on the rising edge
//   rst  - asynchronous reset, active-low (0 = held in reset)
//
// Probe points: memory.m[0:65535] (bytes, little-endian), rs[0:31] (GPRs),
// csr[0:4095] (CSR storage indexed by CSR number).

// Byte-wide unified memory with one fetch port, one load port and one
// byte-enabled store port. Reads are combinational, writes occur at the clock edge.
// Ports:
//   clk     - clock
//   i_addr  - fetch address (byte)       i_data  - fetched word
//   d_addr  - load/store address (byte)  d_rdata - loaded word
//   d_be    - per-byte store enables     d_wdata - store data (lane 0 = d_addr)
module rv32_mem (
  input  logic        clk,
  input  logic [15:0] i_addr,
  output logic [31:0] i_data,
  input  logic [15:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata
);
  logic [7:0] m [0:65535];

  // Byte lanes are assembled from address+k so any alignment works and
  // addresses wrap naturally at 64 KiB.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      i_data[8*k +: 8]  = m[i_addr + 16'(k)];
      d_rdata[8*k +: 8] = m[d_addr + 16'(k)];
    end
  end

  // NOTE: memory arrays are deliberately not reset; the program image is
  // preloaded and must survive reset, and a reset port would prevent RAM mapping.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (d_be[k]) m[d_addr + 16'(k)] <= d_wdata[8*k +: 8];
    end
  end
endmodule

module rv32_core (
  input logic clk,
  input logic rst
);
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MISA    = 12'h301;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [31:0] MISA_VALUE  = 32'h4000_0100;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rs  [0:31];
  logic [31:0] csr [0:4095];

  logic [31:0] instr, ld_word;
  logic [31:0] d_addr, st_data;
  logic [3:0]  st_be;

  rv32_mem memory (
    .clk     (clk),
    .i_addr  (pc_q[15:0]),
    .i_data  (instr),
    .d_addr  (d_addr[15:0]),
    .d_rdata (ld_word),
    .d_be    (rst ? st_be : 4'b0000),
    .d_wdata (st_data)
  );

  // Field decode
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [11:0] csr_num;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign f3      = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign csr_num = instr[31:20];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {instr[31:12], 12'h000};
  assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // x0 is never written, so reading it always yields the reset value 0.
  assign rs1_val = rs[rs1];
  assign rs2_val = rs[rs2];

  function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (fn)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] fn,
                                        input logic [31:0] a, input logic [31:0] b);
    case (fn)
      3'd0:    branch_taken = (a == b);
      3'd1:    branch_taken = (a != b);
      3'd4:    branch_taken = ($signed(a) < $signed(b));
      3'd5:    branch_taken = ($signed(a) >= $signed(b));
      3'd6:    branch_taken = (a < b);
      3'd7:    branch_taken = (a >= b);
      default: branch_taken = 1'b0;
    endcase
  endfunction

  function automatic logic csr_read_only(input logic [11:0] num);
    csr_read_only = (num == CSR_MISA) || (num >= 12'hF11 && num <= 12'hF14);
  endfunction

  logic        rd_we, csr_we, trap, mret;
  logic [31:0] rd_wdata, csr_wdata, csr_old, csr_src, trap_cause;
  logic [31:0] mstatus_trap, mstatus_mret;

  assign csr_old = csr[csr_num];
  assign csr_src = f3[2] ? {27'b0, rs1} : rs1_val;

  // mstatus bit 3 = MIE, bit 7 = MPIE, bits 12:11 = MPP
  always_comb begin
    mstatus_trap        = csr[CSR_MSTATUS];
    mstatus_trap[7]     = csr[CSR_MSTATUS][3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_mret        = csr[CSR_MSTATUS];
    mstatus_mret[3]     = csr[CSR_MSTATUS][7];
    mstatus_mret[7]     = 1'b1;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    pc_d       = pc_q + 32'd4;
    rd_we      = 1'b0;
    rd_wdata   = '0;
    csr_we     = 1'b0;
    csr_wdata  = '0;
    trap       = 1'b0;
    trap_cause = '0;
    mret       = 1'b0;
    st_be      = 4'b0000;
    st_data    = rs2_val;
    d_addr     = rs1_val + imm_i;

    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
      OP_JAL: begin
        rd_we = 1'b1; rd_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j;
      end
      OP_JALR: begin
        rd_we = 1'b1; rd_wdata = pc_q + 32'd4;
        pc_d = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: if (branch_taken(f3, rs1_val, rs2_val)) pc_d = pc_q + imm_b;
      OP_LOAD: begin
        rd_we = 1'b1;
        case (f3)
          3'd0:    rd_wdata = {{24{ld_word[7]}}, ld_word[7:0]};
          3'd1:    rd_wdata = {{16{ld_word[15]}}, ld_word[15:0]};
          3'd4:    rd_wdata = {24'b0, ld_word[7:0]};
          3'd5:    rd_wdata = {16'b0, ld_word[15:0]};
          default: rd_wdata = ld_word;
        endcase
      end
      OP_STORE: begin
        d_addr = rs1_val + imm_s;
        case (f3[1:0])
          2'd0:    st_be = 4'b0001;
          2'd1:    st_be = 4'b0011;
          default: st_be = 4'b1111;
        endcase
      end
      OP_IMM: begin
        rd_we = 1'b1;
        rd_wdata = alu(f3, (f3 == 3'd5) && instr[30], rs1_val, imm_i);
      end
      OP_OP:    begin rd_we = 1'b1; rd_wdata = alu(f3, instr[30], rs1_val, rs2_val); end
      OP_FENCE: ;
      OP_SYSTEM: begin
        if (f3 == 3'd0) begin
          case (csr_num)
            12'h000: begin trap = 1'b1; trap_cause = 32'd11; end
            12'h001: begin trap = 1'b1; trap_cause = 32'd3;  end
            12'h302: begin mret = 1'b1; pc_d = csr[CSR_MEPC]; end
            default: ;  // WFI and other SYSTEM encodings behave as NOPs
          endcase
        end else if (f3 != 3'd4) begin
          rd_we    = 1'b1;
          rd_wdata = csr_old;
          // Set/clear with a zero source never writes; plain write always does.
          csr_we   = ((f3[1:0] == 2'b01) || (rs1 != 5'd0)) && !csr_read_only(csr_num);
          case (f3[1:0])
            2'b01:   csr_wdata = csr_src;
            2'b10:   csr_wdata = csr_old | csr_src;
            default: csr_wdata = csr_old & ~csr_src;
          endcase
        end
      end
      default: begin trap = 1'b1; trap_cause = 32'd2; end
    endcase

    if (trap) begin
      rd_we = 1'b0;
      pc_d  = {csr[CSR_MTVEC][31:2], 2'b00};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) rs[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (rd_we && rd != 5'd0) rs[rd] <= rd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4096; i++) csr[i] <= (i == 32'h301) ? MISA_VALUE : 32'h0;
    end else begin
      if (csr_we) csr[csr_num] <= csr_wdata;
      if (trap) begin
        csr[CSR_MEPC]    <= pc_q;
        csr[CSR_MCAUSE]  <= trap_cause;
        csr[CSR_MTVAL]   <= 32'h0;
        csr[CSR_MSTATUS] <= mstatus_trap;
      end
      if (mret) csr[CSR_MSTATUS] <= mstatus_mret;
    end
  end
endmodule

// File: tb/tb_rv32_core.sv
// Directed bench for rv32_core: preloads a small program into the internal
// memory, steps it a known number of cycles and probes pc, registers, CSRs
// and memory hierarchically against hand-computed values.
module tb_rv32_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_asserts = 0;
  int   n_fail = 0;

  rv32_core dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] csr_op(input logic [11:0] num, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {num, rs1, f3, rd, 7'h73};
  endfunction

  task automatic put_word(input int addr, input logic [31:0] w);
    for (int k = 0; k < 4; k++) dut.memory.m[addr + k] = w[8*k +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) dut.memory.m[a] = 8'h00;
    put_word(32'h000, 32'h00100193);                                   // addi x3,x0,1
    put_word(32'h004, i_type(12'd5, 5'd0, 3'd0, 5'd0, 7'h13));         // addi x0,x0,5
    put_word(32'h008, {7'b0100000, 5'd3, 5'd0, 3'd0, 5'd4, 7'h33});    // sub x4,x0,x3
    put_word(32'h00C, {20'h12345, 5'd5, 7'h37});                       // lui x5,0x12345
    put_word(32'h010, i_type(12'h678, 5'd5, 3'd0, 5'd5, 7'h13));       // addi x5,x5,0x678
    put_word(32'h014, s_type(12'h100, 5'd5, 5'd0, 3'd2));              // sw x5,0x100(x0)
    put_word(32'h018, i_type(12'h101, 5'd0, 3'd0, 5'd6, 7'h03));       // lb x6,0x101(x0)
    put_word(32'h01C, i_type(12'h102, 5'd0, 3'd5, 5'd7, 7'h03));       // lhu x7,0x102(x0)
    put_word(32'h020, i_type(12'h110, 5'd0, 3'd0, 5'd10, 7'h03));      // lb x10,0x110(x0)
    put_word(32'h024, csr_op(12'h340, 5'd5, 3'd1, 5'd0));              // csrw mscratch,x5
    put_word(32'h028, csr_op(12'h340, 5'd0, 3'd2, 5'd8));              // csrr x8,mscratch
    put_word(32'h02C, csr_op(12'h301, 5'd0, 3'd1, 5'd0));              // csrw misa,x0
    put_word(32'h030, csr_op(12'h301, 5'd0, 3'd2, 5'd9));              // csrr x9,misa
    put_word(32'h034, csr_op(12'hF14, 5'd0, 3'd2, 5'd11));             // csrr x11,mhartid
    put_word(32'h038, i_type(12'h200, 5'd0, 3'd0, 5'd12, 7'h13));      // addi x12,x0,0x200
    put_word(32'h03C, csr_op(12'h305, 5'd12, 3'd1, 5'd0));             // csrw mtvec,x12
    put_word(32'h040, 32'h00000073);                                   // ecall
    put_word(32'h044, i_type(12'd7, 5'd0, 3'd0, 5'd13, 7'h13));        // addi x13,x0,7
    put_word(32'h048, i_type(12'hFF0, 5'd0, 3'd0, 5'd15, 7'h13));      // addi x15,x0,-16
    put_word(32'h04C, i_type(12'h402, 5'd15, 3'd5, 5'd16, 7'h13));     // srai x16,x15,2
    put_word(32'h050, b_type(13'd8, 5'd13, 5'd15, 3'd4));              // blt x15,x13,+8
    put_word(32'h054, i_type(12'd1, 5'd0, 3'd0, 5'd17, 7'h13));        // addi x17,x0,1 (skipped)
    put_word(32'h058, {20'h00000, 5'd18, 7'h17});                      // auipc x18,0
    put_word(32'h05C, j_type(21'd8, 5'd1));                            // jal x1,+8
    put_word(32'h060, i_type(12'd2, 5'd0, 3'd0, 5'd17, 7'h13));        // addi x17,x0,2 (skipped)
    put_word(32'h064, j_type(21'd0, 5'd0));                            // j . (halt)
    put_word(32'h200, csr_op(12'h341, 5'd0, 3'd2, 5'd14));             // csrr x14,mepc
    put_word(32'h204, i_type(12'd4, 5'd14, 3'd0, 5'd14, 7'h13));       // addi x14,x14,4
    put_word(32'h208, csr_op(12'h341, 5'd14, 3'd1, 5'd0));             // csrw mepc,x14
    put_word(32'h20C, 32'h30200073);                                   // mret
    dut.memory.m[32'h110] = 8'h80;

    // Reset: two cycles low, release on a falling edge.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", dut.pc_q, 32'h0);
    for (int i = 1; i < 32; i++) check($sformatf("reset_x%0d", i), dut.rs[i], 32'h0);
    check("reset_misa", dut.csr[12'h301], 32'h40000100);
    check("reset_mstatus", dut.csr[12'h300], 32'h0);
    check("reset_mem0", {dut.memory.m[3], dut.memory.m[2], dut.memory.m[1], dut.memory.m[0]},
          32'h00100193);
    rst = 1'b1;

    // ALU and x0
    run(3);
    check("x3_addi", dut.rs[3], 32'h1);
    check("x0_discard", dut.rs[0], 32'h0);
    check("x4_sub", dut.rs[4], 32'hFFFFFFFF);

    // Load/store
    run(6);
    check("x5_li", dut.rs[5], 32'h12345678);
    check("mem_sw", {dut.memory.m[32'h103], dut.memory.m[32'h102],
                     dut.memory.m[32'h101], dut.memory.m[32'h100]}, 32'h12345678);
    check("x6_lb", dut.rs[6], 32'h00000056);
    check("x7_lhu", dut.rs[7], 32'h00001234);
    check("x10_lb_neg", dut.rs[10], 32'hFFFFFF80);

    // CSR access
    run(5);
    check("x8_mscratch", dut.rs[8], 32'h12345678);
    check("x9_misa_ro", dut.rs[9], 32'h40000100);
    check("x11_mhartid", dut.rs[11], 32'h0);
    check("misa_kept", dut.csr[12'h301], 32'h40000100);

    // Trap entry
    run(2);
    check("pc_before_ecall", dut.pc_q, 32'h40);
    check("mtvec", dut.csr[12'h305], 32'h200);
    run(1);
    check("pc_trap", dut.pc_q, 32'h200);
    check("mepc", dut.csr[12'h341], 32'h40);
    check("mcause", dut.csr[12'h342], 32'd11);
    check("mtval", dut.csr[12'h343], 32'h0);
    check("mstatus_trap", dut.csr[12'h300], 32'h00001800);

    // Handler bumps mepc and returns
    run(4);
    check("pc_mret", dut.pc_q, 32'h44);
    check("x14_mepc4", dut.rs[14], 32'h44);
    check("mstatus_mret", dut.csr[12'h300], 32'h00001880);

    // Shifts, branch, auipc, jal, halt loop
    run(8);
    check("x13_addi", dut.rs[13], 32'h7);
    check("x15_neg", dut.rs[15], 32'hFFFFFFF0);
    check("x16_srai", dut.rs[16], 32'hFFFFFFFC);
    check("x17_skipped", dut.rs[17], 32'h0);
    check("x18_auipc", dut.rs[18], 32'h58);
    check("x1_link", dut.rs[1], 32'h60);
    check("pc_halt", dut.pc_q, 32'h64);

    // Asynchronous reset mid-run: state clears immediately, memory is kept.
    rst = 1'b0;
    #1;
    check("rerst_pc", dut.pc_q, 32'h0);
    check("rerst_x3", dut.rs[3], 32'h0);
    check("rerst_mscratch", dut.csr[12'h340], 32'h0);
    check("rerst_misa", dut.csr[12'h301], 32'h40000100);
    check("rerst_mem", {dut.memory.m[32'h103], dut.memory.m[32'h102],
                        dut.memory.m[32'h101], dut.memory.m[32'h100]}, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
